// File: rtl/loop_over_all_nibbles.sv
// Nibble-serial ALU datapath: 4 bits per cycle, LSB first.
// Carries ripple into the upper nibbles of preinit_result when needed.
module loop_over_all_nibbles (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        loop_perm_to_count,
   input  logic [3:0]  ctrl,
   input  logic [2:0]  loop_nibbles_number,
   input  logic        word2_is_negative,
   input  logic [31:0] word1,
   input  logic [31:0] word2,
   input  logic [31:0] preinit_result,
   output logic [31:0] result,
   output logic        busy
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t      r_state;
   logic [31:0] r_result;
   logic        r_carry;
   logic [2:0]  r_idx;

   logic        w_inv;
   logic [1:0]  w_op;
   logic        w_add;
   logic [4:0]  w_pos;
   logic [3:0]  w_w1n;
   logic [3:0]  w_d2;
   logic [3:0]  w_pn;
   logic [3:0]  w_ext;
   logic        w_full;
   logic [3:0]  w_a;
   logic [3:0]  w_b;
   logic [4:0]  w_sum;
   logic [3:0]  w_res;
   logic        w_cnext;
   logic        w_more;

   assign w_inv  = ctrl[3];
   assign w_op   = ctrl[1:0];
   assign w_add  = (w_op == 2'b00);
   assign w_pos  = {r_idx, 2'b00};
   assign w_w1n  = word1[w_pos +: 4];
   assign w_d2   = word2[w_pos +: 4] ^ {4{w_inv}};
   assign w_pn   = preinit_result[w_pos +: 4];
   assign w_ext  = {4{word2_is_negative}} ^ {4{w_inv}};
   assign w_full = (r_idx <= loop_nibbles_number);
   assign w_a    = w_full ? w_w1n : w_pn;
   assign w_b    = w_full ? w_d2 : w_ext;
   assign w_sum  = {1'b0, w_a} + {1'b0, w_b} + {4'b0, r_carry};

   always_comb begin
      w_res   = w_sum[3:0];
      w_cnext = w_sum[4];
      if (w_full) begin
         unique case (w_op)
            2'b00: begin
               w_res   = w_sum[3:0];
               w_cnext = w_sum[4];
            end
            2'b01: begin
               w_res   = w_w1n & w_d2;
               w_cnext = r_carry;
            end
            2'b10: begin
               w_res   = w_w1n | w_d2;
               w_cnext = r_carry;
            end
            2'b11: begin
               w_res   = w_w1n ^ w_d2;
               w_cnext = r_carry;
            end
         endcase
      end
   end

   // Past the last full nibble, keep going only while something can still change.
   assign w_more = (r_idx < loop_nibbles_number) ||
                   ((r_idx != 3'd7) && w_add &&
                    (w_cnext || (w_ext != 4'h0)));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_result <= 32'h0;
         r_carry  <= 1'b0;
         r_idx    <= 3'd0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (loop_perm_to_count) begin
                  r_result <= preinit_result;
                  r_carry  <= ctrl[2];
                  r_idx    <= 3'd0;
                  r_state  <= S_RUN;
               end
            end
            S_RUN: begin
               r_result[w_pos +: 4] <= w_res;
               r_carry              <= w_cnext;
               if (w_more) begin
                  r_idx <= r_idx + 3'd1;
               end else begin
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign result = r_result;
   assign busy   = (r_state == S_RUN) ||
                   ((r_state == S_IDLE) && loop_perm_to_count);

endmodule

// File: tb/tb_loop_over_all_nibbles.sv
// Directed-vector bench for the nibble-serial ALU.
// Expected results and cycle counts are worked out by hand.
module tb_loop_over_all_nibbles;

   logic        clk;
   logic        rst_n;
   logic        perm;
   logic [3:0]  ctrl;
   logic [2:0]  nnum;
   logic        neg;
   logic [31:0] w1;
   logic [31:0] w2;
   logic [31:0] pre;
   logic [31:0] result;
   logic        busy;

   int n_run;
   int n_fail;

   loop_over_all_nibbles dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .loop_perm_to_count  (perm),
      .ctrl                (ctrl),
      .loop_nibbles_number (nnum),
      .word2_is_negative   (neg),
      .word1               (w1),
      .word2               (w2),
      .preinit_result      (pre),
      .result              (result),
      .busy                (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      n_run++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
      end
   endtask

   // Start an op at a negedge, wait for DONE, check result and latency.
   task automatic run_op(input string tag,
                         input logic [3:0] c,
                         input logic [2:0] n,
                         input logic ng,
                         input logic [31:0] a,
                         input logic [31:0] b,
                         input logic [31:0] p,
                         input logic [31:0] exp,
                         input int exp_cyc);
      int cyc;
      @(negedge clk);
      ctrl = c;
      nnum = n;
      neg  = ng;
      w1   = a;
      w2   = b;
      pre  = p;
      perm = 1'b1;
      #1;
      chk({tag, "_busy_req"}, {31'b0, busy}, 32'd1);
      cyc = 0;
      do begin
         @(posedge clk);
         #1;
         cyc++;
      end while (busy && cyc < 20);
      chk({tag, "_cycles"}, cyc, exp_cyc);
      chk({tag, "_result"}, result, exp);
      perm = 1'b0;
      @(posedge clk);
      #1;
      chk({tag, "_hold"}, result, exp);
      chk({tag, "_idle"}, {31'b0, busy}, 32'd0);
   endtask

   initial begin
      n_run  = 0;
      n_fail = 0;
      rst_n  = 1'b0;
      perm   = 1'b0;
      ctrl   = 4'h0;
      nnum   = 3'd0;
      neg    = 1'b0;
      w1     = 32'h0;
      w2     = 32'h0;
      pre    = 32'h0;
      #13;
      chk("rst_result", result, 32'h0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      run_op("pc4", 4'h0, 3'd0, 1'b0, 32'hAEF, 32'h4,
             32'hAEF, 32'h0000_0AF3, 3);
      run_op("addi0", 4'h0, 3'd2, 1'b0, 32'd0, 32'd123,
             32'h0, 32'd123, 4);
      run_op("addi1", 4'h0, 3'd2, 1'b0, 32'd123, 32'd2,
             32'h0, 32'd125, 4);
      run_op("ldaddr", 4'h0, 3'd2, 1'b0, 32'd123, 32'd5,
             32'h0, 32'h80, 4);
      run_op("negimm", 4'h0, 3'd2, 1'b1, 32'h10, 32'hFFFF_FFFF,
             32'h10, 32'h0000_000F, 9);
      run_op("sub", 4'hC, 3'd7, 1'b0, 32'd5, 32'd7,
             32'h0, 32'hFFFF_FFFE, 9);
      run_op("xor", 4'h3, 3'd7, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00,
             32'h0, 32'h0FF0_0FF0, 9);
      run_op("and", 4'h1, 3'd3, 1'b0, 32'h1234_5678, 32'h0000_0F0F,
             32'hAB00_0000, 32'hAB00_0608, 5);
      run_op("or", 4'h2, 3'd1, 1'b0, 32'h0000_0012, 32'h0000_0021,
             32'h5500_0000, 32'h5500_0033, 3);
      run_op("wrap", 4'h0, 3'd0, 1'b0, 32'hFFFF_FFFF, 32'h1,
             32'hFFFF_FFFF, 32'h0, 9);

      // Reset in the middle of a long op.
      @(negedge clk);
      ctrl = 4'hC;
      nnum = 3'd7;
      neg  = 1'b0;
      w1   = 32'd5;
      w2   = 32'd7;
      pre  = 32'h1234_5678;
      perm = 1'b1;
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_result", result, 32'h0);
      chk("midrst_busy_perm", {31'b0, busy}, 32'd1);
      perm = 1'b0;
      #1;
      chk("midrst_busy_low", {31'b0, busy}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_op("fresh", 4'h0, 3'd2, 1'b0, 32'd123, 32'd5,
             32'h0, 32'h80, 4);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
